codificador_inmediato: RTL and testbench

//  Inverse of the immediate decoder. Takes instruction fields plus a 32-bit signed immediate and packs

---
 rtl/codificador_inmediato.sv | 168 ++++++++++++++++
 tb/tb_codificador_inmediato.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codificador_inmediato.sv
// RV32 instruction encoder: packs fields plus a signed immediate into a 32-bit word.
// Two registered stages with valid/ready; words carry an auto-incrementing address.
module codificador_inmediato #(
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       inmediato_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       instruccion_o,
    output logic [ADDR_W-1:0] direccion_o,
    output logic              error_o,
    output logic [ERR_W-1:0]  cuenta_err_o
);

    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0]  ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

    // Stage 1: registered fields, low 20 immediate bits and the in-range flag
    logic        r_s1_valid;
    logic [6:0]  r_s1_op;
    logic [4:0]  r_s1_rd;
    logic [4:0]  r_s1_rs1;
    logic [4:0]  r_s1_rs2;
    logic [2:0]  r_s1_f3;
    logic [6:0]  r_s1_f7;
    logic [19:0] r_s1_imm;
    logic        r_s1_ok;

    // Stage 2: encoded word presented on the outputs
    logic              r_s2_valid;
    logic [31:0]       r_s2_word;
    logic              r_s2_err;
    logic [ADDR_W-1:0] r_addr;
    logic [ERR_W-1:0]  r_cnt;

    logic        w_fits12;
    logic        w_fits20;
    logic        w_ok;
    logic        w_accept;
    logic        w_s2_load;
    logic        w_out_xfer;
    logic [31:0] w_word;

    assign w_fits12 = (&inmediato_i[31:11]) || !(|inmediato_i[31:11]);
    assign w_fits20 = (&inmediato_i[31:19]) || !(|inmediato_i[31:19]);

    always_comb begin
        w_ok = 1'b0;
        case (opcode_i)
            OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH: w_ok = w_fits12;
            OP_JAL:                               w_ok = w_fits20;
            OP_REG:                               w_ok = 1'b1;
            default:                              w_ok = 1'b0;
        endcase
    end

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // ready_o never looks at valid_i, and clear_i blocks any input transfer.
    assign w_out_xfer = r_s2_valid && ready_i;
    assign w_s2_load  = r_s1_valid && (!r_s2_valid || ready_i);
    assign ready_o    = !clear_i && (!r_s1_valid || !r_s2_valid || ready_i);
    assign w_accept   = valid_i && ready_o;

    always_comb begin
        w_word = NOP_WORD;
        if (r_s1_ok) begin
            case (r_s1_op)
                OP_IMM, OP_LOAD:
                    w_word = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
                OP_STORE:
                    w_word = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0], r_s1_op};
                OP_BRANCH:
                    w_word = {r_s1_imm[11], r_s1_imm[9:4], r_s1_rs2, r_s1_rs1, r_s1_f3,
                              r_s1_imm[3:0], r_s1_imm[10], r_s1_op};
                OP_JAL:
                    w_word = {r_s1_imm[19], r_s1_imm[9:0], r_s1_imm[10], r_s1_imm[18:11],
                              r_s1_rd, r_s1_op};
                OP_REG:
                    w_word = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
                default:
                    w_word = NOP_WORD;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_rd    <= '0;
            r_s1_rs1   <= '0;
            r_s1_rs2   <= '0;
            r_s1_f3    <= '0;
            r_s1_f7    <= '0;
            r_s1_imm   <= '0;
            r_s1_ok    <= 1'b0;
        end else if (clear_i) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept || (r_s1_valid && !w_s2_load);
            if (w_accept) begin
                r_s1_op  <= opcode_i;
                r_s1_rd  <= rd_i;
                r_s1_rs1 <= rs1_i;
                r_s1_rs2 <= rs2_i;
                r_s1_f3  <= funct3_i;
                r_s1_f7  <= funct7_i;
                r_s1_imm <= inmediato_i[19:0];
                r_s1_ok  <= w_ok;
            end
        end
    end

    // Output word, error bit and address only change on a load, so they hold under backpressure
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_s2_word  <= '0;
            r_s2_err   <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
        end else if (clear_i) begin
            r_s2_valid <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_s2_word  <= w_word;
                r_s2_err   <= !r_s1_ok;
            end else if (w_out_xfer) begin
                r_s2_valid <= 1'b0;
            end
            if (w_out_xfer) begin
                r_addr <= r_addr + ADDR_ONE;
                if (r_s2_err && !(&r_cnt)) begin
                    r_cnt <= r_cnt + ERR_ONE;
                end
            end
        end
    end

    assign valid_o       = r_s2_valid;
    assign instruccion_o = r_s2_word;
    assign direccion_o   = r_addr;
    assign error_o       = r_s2_err;
    assign cuenta_err_o  = r_cnt;

endmodule

// File: tb/tb_codificador_inmediato.sv
// Directed bench for codificador_inmediato: hand-computed words, an expected-word queue
// checked on every output transfer, plus a narrow-width instance for wrap/saturation.
module tb_codificador_inmediato;

    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_J   = 7'b1101111;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BAD = 7'b0110111;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        valid_i;
    logic        valid2_i;
    logic        ready_i;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;

    logic        ready_o;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [7:0]  addr_o;
    logic        err_o;
    logic [7:0]  cnt_o;

    logic        ready2_o;
    logic        valid2_o;
    logic [31:0] instr2_o;
    logic [1:0]  addr2_o;
    logic        err2_o;
    logic [1:0]  cnt2_o;

    int          checks = 0;
    int          errors = 0;
    int          n_xfer = 0;
    int          acc    = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  exp_addr = '0;
    logic [7:0]  exp_cnt  = '0;

    always #5 clk = ~clk;

    codificador_inmediato #(.ADDR_W(8), .ERR_W(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(valid_i), .ready_o(ready_o),
        .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(f3), .funct7_i(f7),
        .inmediato_i(imm), .valid_o(valid_o), .ready_i(ready_i), .instruccion_o(instr_o),
        .direccion_o(addr_o), .error_o(err_o), .cuenta_err_o(cnt_o)
    );

    codificador_inmediato #(.ADDR_W(2), .ERR_W(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(valid2_i), .ready_o(ready2_o),
        .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(f3), .funct7_i(f7),
        .inmediato_i(imm), .valid_o(valid2_o), .ready_i(ready_i), .instruccion_o(instr2_o),
        .direccion_o(addr2_o), .error_o(err2_o), .cuenta_err_o(cnt2_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive/check phase: 2 time units after the falling edge
    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic set_f(input logic [6:0] op, input logic [4:0] a_rd, input logic [4:0] a_rs1,
                         input logic [4:0] a_rs2, input logic [2:0] a_f3, input logic [6:0] a_f7,
                         input logic [31:0] a_imm);
        opcode = op; rd = a_rd; rs1 = a_rs1; rs2 = a_rs2; f3 = a_f3; f7 = a_f7; imm = a_imm;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] a_rd, input logic [4:0] a_rs1,
                         input logic [4:0] a_rs2, input logic [2:0] a_f3, input logic [6:0] a_f7,
                         input logic [31:0] a_imm, input logic e_err, input logic [31:0] e_word);
        set_f(op, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_imm);
        valid_i = 1'b1;
        #1;
        if (ready_o) begin
            exp_q.push_back({e_err, e_word});
            acc++;
        end
    endtask

    task automatic drive2(input logic [6:0] op, input logic [31:0] a_imm);
        set_f(op, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, a_imm);
        valid2_i = 1'b1;
    endtask

    task automatic idle();
        valid_i  = 1'b0;
        valid2_i = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_addr = '0;
        exp_cnt  = '0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every output transfer pops one expected word, just before the rising edge
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_instr", instr_o, e[31:0]);
                    check("sb_err", 32'(err_o), 32'(e[32]));
                    check("sb_addr", 32'(addr_o), 32'(exp_addr));
                    check("sb_cnt", 32'(cnt_o), 32'(exp_cnt));
                    exp_addr = exp_addr + 8'd1;
                    if (e[32] && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
                    n_xfer++;
                end
            end
        end
    end

    initial begin
        int x0;
        rst_n = 1'b0; clear = 1'b0; ready_i = 1'b1;
        idle();
        set_f(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

        // Reset state
        repeat (3) cyc();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_addr", 32'(addr_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_cnt", 32'(cnt_o), 32'd0);
        rst_n = 1'b1;
        cyc();
        check("rdy_after_rst", 32'(ready_o), 32'd1);

        // I-type, 2-cycle latency
        drive(OP_I, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF1_0093);
        cyc(); idle();
        check("i_lat1_valid", 32'(valid_o), 32'd0);
        cyc();
        check("i_valid", 32'(valid_o), 32'd1);
        check("i_instr", instr_o, 32'hFFF1_0093);
        check("i_addr", 32'(addr_o), 32'd0);
        check("i_err", 32'(err_o), 32'd0);
        cyc();
        check("i_gone", 32'(valid_o), 32'd0);

        // B-type in range and just out of range
        drive(OP_B, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4, 1'b0, 32'h0020_8463);
        cyc();
        drive(OP_B, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd2048, 1'b1, NOP);
        cyc(); idle();
        check("b_instr", instr_o, 32'h0020_8463);
        check("b_err", 32'(err_o), 32'd0);
        cyc();
        check("b_oor_instr", instr_o, NOP);
        check("b_oor_err", 32'(err_o), 32'd1);
        cyc();
        check("b_gone", 32'(valid_o), 32'd0);
        check("b_cnt", 32'(cnt_o), 32'd1);
        check("b_addr", 32'(addr_o), 32'd3);

        // Narrow instance: address wraps at 4, error counter saturates at 3
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k >= 2 && k <= 6) begin
                check("n_valid", 32'(valid2_o), 32'd1);
                check("n_addr", 32'(addr2_o), 32'((k - 2) % 4));
                check("n_err", 32'(err2_o), (k < 6) ? 32'd1 : 32'd0);
            end
            if (k == 6) check("n_instr", instr2_o, 32'hFFF1_0093);
            if (k == 7) begin
                check("n_cnt_sat", 32'(cnt2_o), 32'd3);
                check("n_gone", 32'(valid2_o), 32'd0);
            end
            if (k < 4) drive2(OP_BAD, 32'd0);
            else if (k == 4) drive2(OP_I, 32'hFFFF_FFFF);
            else idle();
        end

        // Remaining encodings and range boundaries, back to back
        cyc(); drive(OP_S, 5'd0, 5'd5, 5'd6, 3'd2, 7'd0, 32'hFFFF_FFFC, 1'b0, 32'hFE62_AE23);
        cyc(); drive(OP_R, 5'd1, 5'd2, 5'd3, 3'd0, 7'b0100000, 32'hDEAD_BEEF, 1'b0, 32'h4031_00B3);
        cyc(); drive(OP_L, 5'd5, 5'd6, 5'd0, 3'd2, 7'd0, 32'hFFFF_F800, 1'b0, 32'h8003_2283);
        cyc(); drive(OP_BAD, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b1, NOP);
        cyc(); drive(OP_J, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0008_0000, 1'b1, NOP);
        cyc(); drive(OP_J, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF8_0000, 1'b0, 32'h8000_006F);
        cyc(); drive(OP_S, 5'd0, 5'd5, 5'd6, 3'd2, 7'd0, 32'hFFFF_F7FF, 1'b1, NOP);
        cyc(); idle();
        drain("enc_drain");
        check("enc_cnt", 32'(cnt_o), 32'd4);
        check("enc_addr", 32'(addr_o), 32'd10);

        // Clear with both stages full
        cyc(); ready_i = 1'b0;
        drive(OP_I, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF1_0093);
        cyc(); drive(OP_R, 5'd1, 5'd2, 5'd3, 3'd0, 7'b0100000, 32'd0, 1'b0, 32'h4031_00B3);
        cyc(); idle();
        check("full_valid", 32'(valid_o), 32'd1);
        check("full_rdy", 32'(ready_o), 32'd0);
        clear = 1'b1;
        drive(OP_R, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0031_00B3);
        cyc(); clear = 1'b0; idle(); ready_i = 1'b1;
        check("clr_valid", 32'(valid_o), 32'd0);
        check("clr_addr", 32'(addr_o), 32'd0);
        check("clr_cnt", 32'(cnt_o), 32'd0);
        model_reset();

        // Clear on an empty pipeline with ready_i=1: offered word must be dropped
        cyc(); clear = 1'b1;
        drive(OP_I, 5'd7, 5'd7, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0, 32'h0073_8393);
        check("clr_rdy_forced", 32'(ready_o), 32'd0);
        cyc(); clear = 1'b0; idle();
        cyc();
        check("clr_discard", 32'(valid_o), 32'd0);
        check("clr_q_empty", 32'(exp_q.size()), 32'd0);

        // 30 back-to-back J words, one per cycle, addresses 0..29
        x0 = n_xfer;
        for (int k = 0; k < 32; k++) begin
            cyc();
            if (k >= 2) check("burst_valid", 32'(valid_o), 32'd1);
            if (k < 30) drive(OP_J, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_07FF, 1'b0,
                              32'h7FF0_006F | (32'(k) << 7));
            else idle();
        end
        drain("burst_drain");
        check("burst_count", 32'(n_xfer - x0), 32'd30);

        // Backpressure: 5 cycles of valid_i with ready_i=0
        cyc(); ready_i = 1'b0; acc = 0;
        for (int k = 0; k < 5; k++) begin
            if (k >= 2) begin
                check("bp_valid", 32'(valid_o), 32'd1);
                check("bp_instr_hold", instr_o, 32'h0052_2193);
                check("bp_addr_hold", 32'(addr_o), 32'd30);
                check("bp_err_hold", 32'(err_o), 32'd0);
            end
            drive(OP_I, 5'd3, 5'd4, 5'd0, 3'd2, 7'd0, 32'(5 + k), 1'b0,
                  32'h0002_2193 | (32'(5 + k) << 20));
            cyc();
        end
        check("bp_accepted", 32'(acc), 32'd2);
        idle(); ready_i = 1'b1;
        drain("bp_drain");
        check("bp_addr_end", 32'(addr_o), 32'd32);

        // Reset in the middle of a burst
        cyc(); drive(OP_BAD, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, NOP);
        cyc(); drive(OP_I, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF1_0093);
        cyc(); drive(OP_R, 5'd1, 5'd2, 5'd3, 3'd0, 7'b0100000, 32'd0, 1'b0, 32'h4031_00B3);
        cyc(); drive(OP_S, 5'd0, 5'd5, 5'd6, 3'd2, 7'd0, 32'hFFFF_FFFC, 1'b0, 32'hFE62_AE23);
        cyc();
        check("mid_valid", 32'(valid_o), 32'd1);
        check("mid_cnt", 32'(cnt_o), 32'd1);
        rst_n = 1'b0; idle();
        #1;
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_instr", instr_o, 32'd0);
        check("arst_addr", 32'(addr_o), 32'd0);
        check("arst_err", 32'(err_o), 32'd0);
        check("arst_cnt", 32'(cnt_o), 32'd0);
        cyc(); rst_n = 1'b1; model_reset();
        cyc(); cyc();
        check("post_rst_valid", 32'(valid_o), 32'd0);
        check("post_rst_addr", 32'(addr_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
